systolic_tile_sequencer: RTL and testbench

Sequences an N×N systolic array through one or more matrix tiles. It accepts a tile-count command and holds the row and column input queues in reset between tiles. For each tile it clears the PE accumulators, pulses the queue start signals, waits until both queues report empty, then times the array drain before flagging the tile done. It sits between the host/DMA command path and the input queues plus PE array.

---
 rtl/systolic_pkg.sv | 38 +++
 rtl/systolic_drain_timer.sv | 36 +++
 rtl/systolic_tile_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_systolic_tile_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg
//   Shared types and width helpers for the systolic tile sequencer.
//   - seq_state_e : sequencer FSM states (3-bit encoding)
//   - cnt_width   : bits needed to hold the values 0..max_val
//   - tile_cnt_w  : width of a tile count (0..MAX_TILES)
//   - tile_idx_w  : width of a tile index (0..MAX_TILES-1)
//   - drain_cnt_w : width of the drain down-counter (0..DRAIN_CYCLES-1)
package systolic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_START  = 3'd2,
      ST_STREAM = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_DONE   = 3'd5
   } seq_state_e;

   function automatic int cnt_width(input int max_val);
      int w;
      w = 1;
      while ((64'd1 << w) <= 64'(max_val)) w++;
      return w;
   endfunction

   function automatic int tile_cnt_w(input int max_tiles);
      return cnt_width(max_tiles);
   endfunction

   function automatic int tile_idx_w(input int max_tiles);
      return (max_tiles > 1) ? cnt_width(max_tiles - 1) : 1;
   endfunction

   function automatic int drain_cnt_w(input int drain_cycles);
      return (drain_cycles > 1) ? cnt_width(drain_cycles - 1) : 1;
   endfunction

endpackage

// File: rtl/systolic_drain_timer.sv
// systolic_drain_timer
//   Loadable down-counter with a zero flag. Loading takes priority over
//   decrementing; the count holds at zero once it gets there.
//   Ports:
//     clk      clock
//     rst      synchronous active-high reset (count -> 0)
//     load     load load_val this cycle
//     load_val value to load
//     dec      decrement (ignored while the count is zero)
//     zero     count == 0
module systolic_drain_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/systolic_tile_sequencer.sv
// systolic_tile_sequencer
//   Runs an N x N systolic array through a command of one or more tiles.
//   Per tile: clear the PE accumulators, pulse the row/column queue starts,
//   wait until both queues are empty, then time the array drain and flag
//   the tile done. The queues are held in reset outside a tile's stream.
//
//   Command handshake: a command is taken on any cycle where
//   cmd_valid_i && cmd_ready_o. cmd_ready_o is high only in IDLE, so
//   cmd_valid_i is ignored in every other state; cmd_valid_i may be held
//   high and is consumed once per visit to IDLE.
//
//   Optional feature: define SEQ_WATCHDOG_EN to add a STREAM timeout of
//   WDOG_CYCLES cycles that sets a sticky error_o and abandons the command.
//   Without it error_o is tied low and STREAM waits indefinitely.
//
//   Ports:
//     clk_i, rst_i         clock, synchronous active-high reset
//     cmd_valid_i/ready_o  command handshake
//     cmd_tiles_i          tiles in the command (saturates at MAX_TILES)
//     row_empty_i          row input queue empty (level)
//     col_empty_i          column input queue empty (level)
//     queue_rstn_o         active-low reset to both input queues
//     row_start_o          one-cycle row queue start
//     col_start_o          one-cycle column queue start
//     acc_clear_o          one-cycle PE accumulator clear
//     tile_done_o          one-cycle pulse at the end of each tile's drain
//     tile_idx_o           index of the current tile
//     done_o               one-cycle pulse at command completion
//     busy_o               sequencer not in IDLE
//     error_o              watchdog timeout, sticky until accept or reset
//     dbg_state            current FSM state (seq_state_e encoding)
module systolic_tile_sequencer
   import systolic_pkg::*;
#(
   parameter int N            = 8,
   parameter int MAX_TILES    = 16,
   parameter int DRAIN_CYCLES = 2 * N,
   parameter int WDOG_CYCLES  = 1024
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               cmd_valid_i,
   output logic                               cmd_ready_o,
   input  logic [tile_cnt_w(MAX_TILES)-1:0]   cmd_tiles_i,
   input  logic                               row_empty_i,
   input  logic                               col_empty_i,
   output logic                               queue_rstn_o,
   output logic                               row_start_o,
   output logic                               col_start_o,
   output logic                               acc_clear_o,
   output logic                               tile_done_o,
   output logic [tile_idx_w(MAX_TILES)-1:0]   tile_idx_o,
   output logic                               done_o,
   output logic                               busy_o,
   output logic                               error_o,
   output logic [2:0]                         dbg_state
);

   localparam int TW = tile_cnt_w(MAX_TILES);
   localparam int IW = tile_idx_w(MAX_TILES);
   localparam int DW = drain_cnt_w(DRAIN_CYCLES);
   localparam logic [TW-1:0] MAX_T      = TW'(MAX_TILES);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

   if (DRAIN_CYCLES < 1 || MAX_TILES < 1 || WDOG_CYCLES < 1) begin : g_cfg_check
      $error("systolic_tile_sequencer: DRAIN_CYCLES, MAX_TILES and WDOG_CYCLES must be >= 1");
   end

   seq_state_e    state, state_next;
   logic [TW-1:0] tiles_q;
   logic [IW-1:0] tile_idx_q;
   logic          error_q;
   logic          drain_zero;
   logic          wdog_hit;
   logic          accept;
   logic          both_empty;
   logic          last_tile;

   assign accept     = cmd_valid_i && cmd_ready_o;
   assign both_empty = row_empty_i && col_empty_i;
   // tiles_q >= 1 whenever a tile is running, so idx+1 == tiles avoids underflow
   assign last_tile  = ((TW'(tile_idx_q) + TW'(1)) == tiles_q);

   // Drain timer is loaded on the STREAM->DRAIN transition so DRAIN lasts
   // exactly DRAIN_CYCLES cycles; tile_done_o fires on its zero cycle.
   systolic_drain_timer #(
      .W (DW)
   ) u_drain_timer (
      .clk      (clk_i),
      .rst      (rst_i),
      .load     ((state == ST_STREAM) && both_empty),
      .load_val (DRAIN_LOAD),
      .dec      (state == ST_DRAIN),
      .zero     (drain_zero)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               state_next = (cmd_tiles_i != '0) ? ST_CLEAR : ST_DONE;
            end
         end
         ST_CLEAR:  state_next = ST_START;
         ST_START:  state_next = ST_STREAM;
         ST_STREAM: begin
            // Completion wins over a timeout landing in the same cycle.
            if (both_empty) begin
               state_next = ST_DRAIN;
            end else if (wdog_hit) begin
               state_next = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (drain_zero) begin
               state_next = last_tile ? ST_DONE : ST_CLEAR;
            end
         end
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Outputs decode from the registered state only.
   always_comb begin
      cmd_ready_o  = 1'b0;
      busy_o       = 1'b1;
      queue_rstn_o = 1'b0;
      row_start_o  = 1'b0;
      col_start_o  = 1'b0;
      acc_clear_o  = 1'b0;
      tile_done_o  = 1'b0;
      done_o       = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready_o = 1'b1;
            busy_o      = 1'b0;
         end
         ST_CLEAR: acc_clear_o = 1'b1;
         ST_START: begin
            queue_rstn_o = 1'b1;
            row_start_o  = 1'b1;
            col_start_o  = 1'b1;
         end
         ST_STREAM: queue_rstn_o = 1'b1;
         ST_DRAIN: begin
            queue_rstn_o = 1'b1;
            tile_done_o  = drain_zero;
         end
         ST_DONE:  done_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tiles_q    <= '0;
         tile_idx_q <= '0;
      end else if (accept) begin
         tiles_q    <= (cmd_tiles_i > MAX_T) ? MAX_T : cmd_tiles_i;
         tile_idx_q <= '0;
      end else if ((state == ST_DRAIN) && drain_zero && !last_tile) begin
         tile_idx_q <= tile_idx_q + IW'(1);
      end
   end

`ifdef SEQ_WATCHDOG_EN
   localparam int WW = cnt_width(WDOG_CYCLES);
   logic [WW-1:0] wdog_q;

   // Counter is 0 on the first STREAM cycle, so the timeout is taken on the
   // cycle it reaches WDOG_CYCLES-1 and IDLE follows WDOG_CYCLES cycles
   // after STREAM entry.
   assign wdog_hit = (state == ST_STREAM) && (wdog_q == WW'(WDOG_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wdog_q  <= '0;
         error_q <= 1'b0;
      end else begin
         if (state == ST_START) begin
            wdog_q <= '0;
         end else if (state == ST_STREAM) begin
            wdog_q <= wdog_q + WW'(1);
         end
         if (accept) begin
            error_q <= 1'b0;
         end else if (wdog_hit && !both_empty) begin
            error_q <= 1'b1;
         end
      end
   end
`else
   assign wdog_hit = 1'b0;
   assign error_q  = 1'b0;
`endif

   assign tile_idx_o = tile_idx_q;
   assign error_o    = error_q;
   assign dbg_state  = state;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// tb_systolic_tile_sequencer
//   Bench for systolic_tile_sequencer (N=4, DRAIN_CYCLES=8, MAX_TILES=16,
//   WDOG_CYCLES=16). Each command is planned up front from the timing rules:
//   expected pulse cycles go into per-pulse queues and expected levels
//   (busy, queue reset, error) into per-cycle arrays. A negedge monitor
//   compares the DUT against them. Build with SEQ_WATCHDOG_EN to add the
//   timeout scenario.
module tb_systolic_tile_sequencer;
   import systolic_pkg::*;

   localparam int N         = 4;
   localparam int MAX_TILES = 16;
   localparam int DRAIN     = 2 * N;
   localparam int WDOG      = 16;
   localparam int DEPTH     = 8192;

   localparam int P_CLR  = 0;
   localparam int P_ROW  = 1;
   localparam int P_COL  = 2;
   localparam int P_TD   = 3;
   localparam int P_DONE = 4;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [4:0] cmd_tiles = '0;
   logic       row_empty = 1'b0;
   logic       col_empty = 1'b0;
   logic       cmd_ready, queue_rstn, row_start, col_start, acc_clear;
   logic       tile_done, done, busy, error;
   logic [3:0] tile_idx;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   systolic_tile_sequencer #(
      .N            (N),
      .MAX_TILES    (MAX_TILES),
      .DRAIN_CYCLES (DRAIN),
      .WDOG_CYCLES  (WDOG)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_tiles_i  (cmd_tiles),
      .row_empty_i  (row_empty),
      .col_empty_i  (col_empty),
      .queue_rstn_o (queue_rstn),
      .row_start_o  (row_start),
      .col_start_o  (col_start),
      .acc_clear_o  (acc_clear),
      .tile_done_o  (tile_done),
      .tile_idx_o   (tile_idx),
      .done_o       (done),
      .busy_o       (busy),
      .error_o      (error),
      .dbg_state    (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic        exp_busy [DEPTH];
   logic        exp_rstn [DEPTH];
   logic        exp_err  [DEPTH];
   logic [31:0] exp_q [5][$];   // {idx[7:0], cycle[23:0]}
   string       pulse_name [5] = '{"acc_clear", "row_start", "col_start", "tile_done", "done"};
   int          n_checks = 0;
   int          n_pass   = 0;
   bit          check_en = 1'b0;

   task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, expv);
   endtask

   function automatic void push_pulse(input int id, input int c, input int idx);
      logic [31:0] cv, iv;
      cv = c;
      iv = idx;
      exp_q[id].push_back({iv[7:0], cv[23:0]});
   endfunction

   function automatic void fill_busy(input int a, input int b);
      for (int c = a; c <= b; c++) if (c >= 0 && c < DEPTH) exp_busy[c] = 1'b1;
   endfunction

   function automatic void fill_rstn(input int a, input int b);
      for (int c = a; c <= b; c++) if (c >= 0 && c < DEPTH) exp_rstn[c] = 1'b1;
   endfunction

   function automatic void set_err_from(input int a, input logic v);
      for (int c = a; c < DEPTH; c++) if (c >= 0) exp_err[c] = v;
   endfunction

   task automatic check_pulse(input int id, input logic seen, input int c);
      logic [31:0] f;
      int          fc;
      while (exp_q[id].size() > 0) begin
         f  = exp_q[id][0];
         fc = int'(f[23:0]);
         if (fc < c) begin
            n_checks++;
            $display("FAIL %s missed: expected pulse at cycle %0d, got none", pulse_name[id], fc);
            void'(exp_q[id].pop_front());
         end else break;
      end
      if (seen) begin
         n_checks++;
         if (exp_q[id].size() == 0) begin
            $display("FAIL %s unexpected pulse at cycle %0d, expected none", pulse_name[id], c);
         end else begin
            f  = exp_q[id][0];
            fc = int'(f[23:0]);
            if (fc != c) begin
               $display("FAIL %s pulse at cycle %0d, expected at cycle %0d", pulse_name[id], c, fc);
            end else begin
               void'(exp_q[id].pop_front());
               if (id == P_TD && {4'd0, tile_idx} != f[31:24])
                  $display("FAIL tile_idx at tile_done cycle %0d: got %0d expected %0d", c, tile_idx, f[31:24]);
               else
                  n_pass++;
            end
         end
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (check_en && cyc < DEPTH) begin
         chk("busy",       cyc, 32'(busy),       32'(exp_busy[cyc]));
         chk("cmd_ready",  cyc, 32'(cmd_ready),  32'(!exp_busy[cyc]));
         chk("queue_rstn", cyc, 32'(queue_rstn), 32'(exp_rstn[cyc]));
         chk("error",      cyc, 32'(error),      32'(exp_err[cyc]));
         check_pulse(P_CLR,  acc_clear, cyc);
         check_pulse(P_ROW,  row_start, cyc);
         check_pulse(P_COL,  col_start, cyc);
         check_pulse(P_TD,   tile_done, cyc);
         check_pulse(P_DONE, done,      cyc);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_until(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issues one command at the current cycle. row_d/col_d: cycles after
   // STREAM entry at which each queue reports empty (<0 = random per tile).
   // rst_off > 0: pulse reset rst_off cycles after both empties of tile 0.
   task automatic run_cmd(input int tiles_req, input int row_d, input int col_d, input int rst_off);
      int t, eff, p, s, last_k, end_c, a, b, lo, hi;
      int sr_a [MAX_TILES];
      int sc_a [MAX_TILES];
      t   = cyc;
      eff = (tiles_req > MAX_TILES) ? MAX_TILES : tiles_req;
      set_err_from(t + 1, 1'b0);
      if (eff == 0) begin
         push_pulse(P_DONE, t + 1, 0);
         fill_busy(t + 1, t + 1);
         end_c  = t + 2;
         last_k = -1;
      end else begin
         p      = t + 1;
         last_k = (rst_off > 0) ? 0 : eff - 1;
         end_c  = 0;
         for (int k = 0; k <= last_k; k++) begin
            a = (row_d < 0) ? int'($urandom_range(0, 10)) : row_d;
            b = (col_d < 0) ? int'($urandom_range(0, 10)) : col_d;
            sr_a[k] = p + 2 + a;
            sc_a[k] = p + 2 + b;
            s = (sr_a[k] > sc_a[k]) ? sr_a[k] : sc_a[k];
            push_pulse(P_CLR, p, 0);
            push_pulse(P_ROW, p + 1, 0);
            push_pulse(P_COL, p + 1, 0);
            if (rst_off > 0) begin
               fill_rstn(p + 1, s + rst_off);
               end_c = s + rst_off + 1;
            end else begin
               fill_rstn(p + 1, s + DRAIN);
               push_pulse(P_TD, s + DRAIN, k);
               p = s + DRAIN + 1;
            end
         end
         if (rst_off == 0) begin
            push_pulse(P_DONE, p, 0);
            end_c = p + 1;
         end
         fill_busy(t + 1, end_c - 1);
      end

      // Command, kept valid one extra cycle with other data: must be ignored.
      cmd_valid = 1'b1;
      cmd_tiles = 5'(tiles_req);
      wait_until(t + 1);
      cmd_tiles = 5'($urandom_range(0, 31));
      wait_until(t + 2);
      cmd_valid = 1'b0;

      for (int k = 0; k <= last_k; k++) begin
         lo = (sr_a[k] < sc_a[k]) ? sr_a[k] : sc_a[k];
         hi = (sr_a[k] > sc_a[k]) ? sr_a[k] : sc_a[k];
         wait_until(lo);
         if (sr_a[k] == lo) row_empty = 1'b1;
         if (sc_a[k] == lo) col_empty = 1'b1;
         wait_until(hi);
         row_empty = 1'b1;
         col_empty = 1'b1;
         wait_until(hi + 1);
         row_empty = 1'b0;
         col_empty = 1'b0;
         if (rst_off > 0) begin
            wait_until(hi + rst_off);
            rst = 1'b1;
            wait_until(hi + rst_off + 1);
            rst = 1'b0;
            chk("tile_idx after reset", cyc, 32'(tile_idx), 32'd0);
            chk("state after reset", cyc, 32'(dbg_state), 32'(ST_IDLE));
         end
      end
      wait_until(end_c);
   endtask

`ifdef SEQ_WATCHDOG_EN
   task automatic run_wdog();
      int t, e;
      t = cyc;
      e = t + 3;
      set_err_from(t + 1, 1'b0);
      set_err_from(e + WDOG, 1'b1);
      fill_busy(t + 1, e + WDOG - 1);
      fill_rstn(t + 2, e + WDOG - 1);
      push_pulse(P_CLR, t + 1, 0);
      push_pulse(P_ROW, t + 2, 0);
      push_pulse(P_COL, t + 2, 0);
      cmd_valid = 1'b1;
      cmd_tiles = 5'd1;
      wait_until(t + 1);
      cmd_valid = 1'b0;
      wait_until(e + WDOG);
      chk("state after timeout", cyc, 32'(dbg_state), 32'(ST_IDLE));
      wait_until(cyc + 3);
   endtask
`endif

   // ---------------- main sequence ----------------
   initial begin
      for (int c = 0; c < DEPTH; c++) begin
         exp_busy[c] = 1'b0;
         exp_rstn[c] = 1'b0;
         exp_err[c]  = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_en = 1'b1;
      wait_until(3);
      rst = 1'b0;

      wait_until(10);
      run_cmd(1, 7, 7, 0);          // accept 10, empties 20
      wait_until(cyc + 2);
      run_cmd(3, 5, 5, 0);          // empties 6 cycles after each START
      run_cmd(1, 2, 5, 0);          // back-to-back, row empty before col
      run_cmd(1, 6, 0, 0);          // col empty before row
      run_cmd(0, 0, 0, 0);          // zero tiles
      run_cmd(1, 0, 0, 0);          // empties on the first STREAM cycle
      run_cmd(2, 3, 3, 4);          // reset in the middle of DRAIN
      wait_until(cyc + 2);
      run_cmd(1, 1, 1, 0);
      run_cmd(20, -1, -1, 0);       // saturates to MAX_TILES
      for (int i = 0; i < 8; i++) begin
         wait_until(cyc + int'($urandom_range(0, 3)));
         run_cmd(int'($urandom_range(0, 5)), -1, -1, 0);
      end
`ifdef SEQ_WATCHDOG_EN
      run_wdog();
      run_cmd(1, 2, 2, 0);          // accept clears the sticky error
`endif
      wait_until(cyc + 5);
      check_en = 1'b0;
      for (int id = 0; id < 5; id++) begin
         while (exp_q[id].size() > 0) begin
            n_checks++;
            $display("FAIL %s missed: expected pulse at cycle %0d, got none", pulse_name[id], exp_q[id][0] & 32'h00ff_ffff);
            void'(exp_q[id].pop_front());
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #(DEPTH * 10);
      $display("FAIL time limit: simulation reached cycle %0d without finishing", cyc);
      $fatal(1);
   end

endmodule
